// File: rtl/board_pkg.sv
// Board-level constants shared by the Basys3 switch front end.
package board_pkg;

    localparam int unsigned CLK_HZ                = 100_000_000;
    localparam int unsigned DEBOUNCE_MS           = 10;
    localparam int unsigned DEFAULT_STABLE_CYCLES = CLK_HZ / 1000 * DEBOUNCE_MS;

    // Counter width able to hold 0..stable_cycles.
    function automatic int unsigned cnt_width(input int unsigned stable_cycles);
        return $clog2(stable_cycles + 1);
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// One switch bit: 2-FF synchronizer, stable-time counter filter and edge strobes.
module debounce_bit
    import board_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic db,
    output logic rise,
    output logic fall,
    output logic change_c
);

    localparam int unsigned      CNT_W   = cnt_width(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;
    logic             mismatch_c;

    assign mismatch_c = (sync2 != db);
    // High on the edge that accepts the new level; feeds the shared change flag.
    assign change_c   = mismatch_c && (cnt == CNT_MAX);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            db    <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            rise  <= change_c &  sync2;
            fall  <= change_c & ~sync2;
            if (change_c) begin
                db  <= sync2;
                cnt <= '0;
            end else if (mismatch_c) begin
                cnt <= cnt + CNT_W'(1);
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/switch_debouncer.sv
// Debounces WIDTH slide switches; strobes rise/fall per bit and a shared change flag.
module switch_debouncer
    import board_pkg::*;
#(
    parameter int unsigned WIDTH         = 3,
    parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_db,
    output logic [WIDTH-1:0] sw_rise,
    output logic [WIDTH-1:0] sw_fall,
    output logic             sw_changed
);

    logic [WIDTH-1:0] change_c;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .STABLE_CYCLES(STABLE_CYCLES)
        ) u_bit (
            .clk     (clk),
            .rst_n   (rst_n),
            .raw     (sw_raw[i]),
            .db      (sw_db[i]),
            .rise    (sw_rise[i]),
            .fall    (sw_fall[i]),
            .change_c(change_c[i])
        );
    end

    // Registered from the pre-strobe terms so it lines up with the strobes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sw_changed <= 1'b0;
        end else begin
            sw_changed <= |change_c;
        end
    end

endmodule
